// File: rtl/branch_hazard_ctrl_if.sv
// ID-stage branch hazard bus: decode/EX/MEM tags in, pipeline enables and flush out.
interface branch_hazard_ctrl_if;
  logic       hold;
  logic       br_id;
  logic       use_rs1;
  logic       use_rs2;
  logic [1:0] float_read;
  logic [4:0] rs1id;
  logic [4:0] rs2id;
  logic [4:0] rdex;
  logic       wbex;
  logic       fw_ie;
  logic [4:0] rdmem;
  logic       wbmem;
  logic       fw_imem;
  logic       br_taken;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       stalling;

  modport master (
    output hold, br_id, use_rs1, use_rs2, float_read, rs1id, rs2id,
           rdex, wbex, fw_ie, rdmem, wbmem, fw_imem, br_taken,
    input  pc_we, ifid_we, idex_bubble, ifid_flush, stalling
  );

  modport slave (
    input  hold, br_id, use_rs1, use_rs2, float_read, rs1id, rs2id,
           rdex, wbex, fw_ie, rdmem, wbmem, fw_imem, br_taken,
    output pc_we, ifid_we, idex_bubble, ifid_flush, stalling
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage stall/flush controller for branches forwarded only from WB.
// Optional stall-cycle counter enabled by BR_HAZ_PERF_CNT_EN.
module branch_hazard_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_hazard_ctrl_if.slave    bus
`ifdef BR_HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(MAX_STALL + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_need;
  logic          r_ifid_flush;
  logic          w_stalling;
  logic          w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;

  // Source match against a producer, honouring the int/FP register-file split
  assign w_rs1_ex  = bus.use_rs1 && bus.wbex  && (bus.rdex  != 5'd0) &&
                     (bus.rdex  == bus.rs1id) && (bus.float_read[1] == bus.fw_ie);
  assign w_rs2_ex  = bus.use_rs2 && bus.wbex  && (bus.rdex  != 5'd0) &&
                     (bus.rdex  == bus.rs2id) && (bus.float_read[0] == bus.fw_ie);
  assign w_rs1_mem = bus.use_rs1 && bus.wbmem && (bus.rdmem != 5'd0) &&
                     (bus.rdmem == bus.rs1id) && (bus.float_read[1] == bus.fw_imem);
  assign w_rs2_mem = bus.use_rs2 && bus.wbmem && (bus.rdmem != 5'd0) &&
                     (bus.rdmem == bus.rs2id) && (bus.float_read[0] == bus.fw_imem);

  always_comb begin
    w_need = '0;
    if (bus.br_id) begin
      if (w_rs1_ex || w_rs2_ex)        w_need = CW'(MAX_STALL);
      else if (w_rs1_mem || w_rs2_mem) w_need = CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and stall decision; hold freezes state and counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stalling  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.br_id && (w_need != '0) && !bus.hold) begin
          w_stalling  = 1'b1;
          w_cnt_nxt   = w_need - CW'(1);
          w_state_nxt = ((w_need - CW'(1)) != '0) ? STALL : IDLE;
        end
      end
      STALL: begin
        w_stalling = 1'b1;
        if (!bus.hold) begin
          if (r_cnt <= CW'(1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.stalling    = w_stalling;
  assign bus.pc_we       = !bus.hold && !w_stalling;
  assign bus.ifid_we     = !bus.hold && !w_stalling;
  assign bus.idex_bubble = !bus.hold && w_stalling;

  // One-cycle IF/ID kill after a taken redirect resolved in ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_ifid_flush <= 1'b0;
    else if (!bus.hold) r_ifid_flush <= bus.br_taken && bus.br_id && !w_stalling;
  end

  assign bus.ifid_flush = r_ifid_flush;

`ifdef BR_HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_stall_cycles <= '0;
    else if (w_stalling && !bus.hold) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; build with BR_HAZ_PERF_CNT_EN to cover the counter.
module tb_branch_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_hazard_ctrl_if bus ();

`ifdef BR_HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  branch_hazard_ctrl #(.CNT_W(32), .MAX_STALL(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BR_HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hold = 0; bus.br_id = 0; bus.use_rs1 = 0; bus.use_rs2 = 0;
    bus.float_read = 2'b00; bus.rs1id = 0; bus.rs2id = 0;
    bus.rdex = 0; bus.wbex = 0; bus.fw_ie = 0;
    bus.rdmem = 0; bus.wbmem = 0; bus.fw_imem = 0; bus.br_taken = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // EX producer for rs1=5 on the integer file
  task automatic drive_ex_dep();
    bus.br_id = 1; bus.use_rs1 = 1; bus.rs1id = 5;
    bus.rdex = 5; bus.wbex = 1; bus.fw_ie = 0; bus.float_read = 2'b00;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #3;
    checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL reset_pc_we: got %b expected 1", bus.pc_we); end
    checks++; if (bus.ifid_we !== 1'b1) begin errors++; $display("FAIL reset_ifid_we: got %b expected 1", bus.ifid_we); end
    checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b expected 0", bus.idex_bubble); end
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL reset_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", bus.ifid_flush); end
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_rst_mid_stall();
    drive_ex_dep();
    #1;
    checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: got %b expected 1", bus.stalling); end
    tick();
    bus.rdex = 0; bus.wbex = 0;
    #1;
    rst = 1;
    #1;
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL rstmid_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL rstmid_pc_we: got %b expected 1", bus.pc_we); end
    checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL rstmid_bubble: got %b expected 0", bus.idex_bubble); end
`ifdef BR_HAZ_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", stall_cycles); end
`endif
    #1;
    rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_ex_dep();
    drive_ex_dep();
    #1;
    checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL ex_c0_stalling: got %b expected 1", bus.stalling); end
    checks++; if (bus.idex_bubble !== 1'b1) begin errors++; $display("FAIL ex_c0_bubble: got %b expected 1", bus.idex_bubble); end
    checks++; if (bus.pc_we !== 1'b0) begin errors++; $display("FAIL ex_c0_pc_we: got %b expected 0", bus.pc_we); end
    checks++; if (bus.ifid_we !== 1'b0) begin errors++; $display("FAIL ex_c0_ifid_we: got %b expected 0", bus.ifid_we); end
    tick();
    // producer advanced to MEM; STALL must ignore it
    bus.rdex = 0; bus.wbex = 0; bus.rdmem = 5; bus.wbmem = 1;
    #1;
    checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL ex_c1_stalling: got %b expected 1", bus.stalling); end
    checks++; if (bus.idex_bubble !== 1'b1) begin errors++; $display("FAIL ex_c1_bubble: got %b expected 1", bus.idex_bubble); end
    tick();
    bus.rdmem = 0; bus.wbmem = 0;
    #1;
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL ex_c2_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL ex_c2_pc_we: got %b expected 1", bus.pc_we); end
    checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL ex_c2_bubble: got %b expected 0", bus.idex_bubble); end
`ifdef BR_HAZ_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL ex_perf_cnt: got %0d expected 2", stall_cycles); end
`endif
    clear_inputs();
    tick();
  endtask

  task automatic test_mem_dep();
    bus.br_id = 1; bus.use_rs2 = 1; bus.rs2id = 7;
    bus.rdmem = 7; bus.wbmem = 1; bus.rdex = 9; bus.wbex = 1;
    #1;
    checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL mem_c0_stalling: got %b expected 1", bus.stalling); end
    checks++; if (bus.idex_bubble !== 1'b1) begin errors++; $display("FAIL mem_c0_bubble: got %b expected 1", bus.idex_bubble); end
    tick();
    bus.rdmem = 0; bus.wbmem = 0; bus.wbex = 0;
    #1;
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL mem_c1_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL mem_c1_pc_we: got %b expected 1", bus.pc_we); end
    clear_inputs();
    tick();
  endtask

  task automatic test_no_stall();
    // FP producer vs integer source
    bus.br_id = 1; bus.use_rs1 = 1; bus.rs1id = 3;
    bus.rdex = 3; bus.wbex = 1; bus.fw_ie = 1; bus.float_read = 2'b00;
    #1;
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL rf_mismatch_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL rf_mismatch_pc_we: got %b expected 1", bus.pc_we); end
    // FP producer vs FP source does stall
    bus.float_read = 2'b10;
    #1;
    checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL fp_match_stalling: got %b expected 1", bus.stalling); end
    // x0 never creates a dependency
    bus.float_read = 2'b00; bus.fw_ie = 0; bus.rs1id = 0; bus.rdex = 0;
    #1;
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL rd0_stalling: got %b expected 0", bus.stalling); end
    // non-branch with a live EX match
    bus.rs1id = 4; bus.rdex = 4; bus.br_id = 0;
    #1;
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL nonbranch_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL nonbranch_bubble: got %b expected 0", bus.idex_bubble); end
    clear_inputs();
    tick();
  endtask

  task automatic test_hold();
    drive_ex_dep();
    tick();
    bus.rdex = 0; bus.wbex = 0;
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.pc_we !== 1'b0) begin errors++; $display("FAIL hold_pc_we[%0d]: got %b expected 0", i, bus.pc_we); end
      checks++; if (bus.idex_bubble !== 1'b0) begin errors++; $display("FAIL hold_bubble[%0d]: got %b expected 0", i, bus.idex_bubble); end
      checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL hold_stalling[%0d]: got %b expected 1", i, bus.stalling); end
      tick();
    end
    bus.hold = 0;
    #1;
    checks++; if (bus.stalling !== 1'b1) begin errors++; $display("FAIL hold_rel_stalling: got %b expected 1", bus.stalling); end
    checks++; if (bus.idex_bubble !== 1'b1) begin errors++; $display("FAIL hold_rel_bubble: got %b expected 1", bus.idex_bubble); end
    tick();
    checks++; if (bus.stalling !== 1'b0) begin errors++; $display("FAIL hold_done_stalling: got %b expected 0", bus.stalling); end
    checks++; if (bus.pc_we !== 1'b1) begin errors++; $display("FAIL hold_done_pc_we: got %b expected 1", bus.pc_we); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    bus.br_id = 1; bus.br_taken = 1;
    tick();
    bus.br_id = 0; bus.br_taken = 0;
    checks++; if (bus.ifid_flush !== 1'b1) begin errors++; $display("FAIL flush_set: got %b expected 1", bus.ifid_flush); end
    tick();
    checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b expected 0", bus.ifid_flush); end
    // taken indication while stalling is ignored
    drive_ex_dep();
    bus.br_taken = 1;
    tick();
    bus.rdex = 0; bus.wbex = 0;
    checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL flush_stall_c0: got %b expected 0", bus.ifid_flush); end
    tick();
    checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL flush_stall_c1: got %b expected 0", bus.ifid_flush); end
    tick();
    checks++; if (bus.ifid_flush !== 1'b1) begin errors++; $display("FAIL flush_after_stall: got %b expected 1", bus.ifid_flush); end
    clear_inputs();
    tick();
    checks++; if (bus.ifid_flush !== 1'b0) begin errors++; $display("FAIL flush_final: got %b expected 0", bus.ifid_flush); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1;
    clear_inputs();
    test_reset();
    test_rst_mid_stall();
    test_ex_dep();
    test_mem_dep();
    test_no_stall();
    test_hold();
    test_flush();
    chk("final_pc_we", 32'(bus.pc_we), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Stall/flush controller in the ID stage, directly upstream of the branch operand forwarding unit. Branch and JALR operands in ID are forwarded only from WB, so a branch whose source is still being produced in EX or MEM must wait. This block detects that dependency, freezes PC and IF/ID, and injects bubbles into ID/EX for the exact number of cycles. It also issues the one-cycle IF/ID flush after a taken redirect. Integer and float register files are kept separate using the float_read and fw_* tags.

Parameters:
CNT_W, 32, width of the optional stall-cycle performance counter
MAX_STALL, 2, largest stall count; EX-stage producer with WB-only branch forwarding

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-high
hold  input  1  global pipeline freeze (memory wait); all state holds
br_id  input  1  ID instruction is a branch or JALR
use_rs1  input  1  ID instruction reads rs1
use_rs2  input  1  ID instruction reads rs2
float_read  input  2  [1]=rs1 is FP reg, [0]=rs2 is FP reg
rs1id  input  5  ID source 1
rs2id  input  5  ID source 2
rdex  input  5  EX destination
wbex  input  1  EX writes back
fw_ie  input  1  EX destination is FP
rdmem  input  5  MEM destination
wbmem  input  1  MEM writes back
fw_imem  input  1  MEM destination is FP
br_taken  input  1  branch in ID resolved taken (valid only when not stalling)
pc_we  output  1  PC write enable
ifid_we  output  1  IF/ID write enable
idex_bubble  output  1  ID/EX loads a NOP
ifid_flush  output  1  IF/ID loads a NOP (registered)
stalling  output  1  hazard stall active this cycle

Behaviour:
- Match rule for source s (rs1/rs2) against stage X: wbX && rdX!=0 && rdX==rsSid && float_read bit == fw_X && use_rsS.
- need = 2 if any EX match; else 1 if any MEM match; else 0. need is evaluated only when br_id=1.
- FSM states: IDLE and STALL. Down-counter cnt has 2 bits.
- IDLE, br_id && need>0 && !hold:
  - stalling=1, pc_we=0, ifid_we=0, idex_bubble=1 in the same cycle (combinational).
  - cnt<=need-1; next state = STALL if need-1>0, else IDLE.
- STALL:
  - Outputs are the same as the stalling case above.
  - EX and MEM inputs are ignored.
  - cnt decrements each non-hold cycle; when cnt==1 the next state is IDLE with cnt<=0.
- Not stalling: pc_we=1, ifid_we=1, idex_bubble=0.
- hold=1:
  - pc_we=0, ifid_we=0, idex_bubble=0.
  - State, cnt and ifid_flush hold their values.
  - stalling reflects the held state.
- Redirect:
  - ifid_flush<=br_taken && br_id && !stalling && !hold, registered for 1 cycle, then cleared.
  - br_taken is ignored while stalling.
- Branch in ID with need=0 proceeds with no bubble.
- A non-branch instruction in ID never stalls.
- Reset (asynchronous, any state, including mid-stall): state=IDLE, cnt=0, ifid_flush=0. Outputs then: pc_we=1, ifid_we=1, idex_bubble=0, stalling=0.

Optional Feature:
BR_HAZ_PERF_CNT_EN:
- Defined: adds output stall_cycles [CNT_W-1:0]. It resets to 0, increments on every cycle with stalling=1 && !hold, and wraps modulo 2^CNT_W.
- Undefined: no port and no counter logic.

Test Plan:
- EX dependency: beq rs1id=5, rdex=5, wbex=1, fw_ie=0, float_read=00 -> stalling=1 for exactly 2 cycles; idex_bubble=1 both cycles; pc_we=1 on the 3rd cycle.
- MEM dependency: rs2id=7, rdmem=7, wbmem=1, no EX match -> 1 stall cycle, then proceeds.
- Reg-file mismatch: rdex=3=rs1id, fw_ie=1, float_read=00 -> no stall. Same case with rd=0 -> no stall.
- hold=1 in the second stall cycle for 3 cycles -> cnt holds, pc_we=0, idex_bubble=0. After release exactly 1 stall cycle remains.
- Taken branch with need=0, br_taken=1 -> ifid_flush=1 the next cycle only. br_taken=1 during a stall -> no flush.
- rst asserted mid-STALL -> outputs return to reset values asynchronously. With the macro defined, stall_cycles=0 and then counts 2 for the EX case.
